// File: rtl/param_datapath.sv
// param_datapath: self-sequencing register-file datapath.
// A command is captured on a start handshake. An internal FSM then walks
// read-A, read-B, execute and write-back without further controller help.
module param_datapath #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic [1:0]       ALUop,
  input  logic [1:0]       shift,
  input  logic             wb,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rn,
  input  logic [AW-1:0]    rm,
  input  logic [4:0]       imm5,
  input  logic [7:0]       sximm8,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       status_out,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam logic [1:0] KIND_RR   = 2'b00;
  localparam logic [1:0] KIND_RI   = 2'b01;
  localparam logic [1:0] KIND_MOVI = 2'b10;
  localparam logic [1:0] KIND_MOVR = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;
  logic             r_done;

  // Latched command fields; the ports are free to change after accept.
  logic [1:0]       r_kind;
  logic [1:0]       r_op;
  logic [1:0]       r_shift;
  logic             r_wb;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_rn;
  logic [AW-1:0]    r_rm;
  logic [4:0]       r_imm5;
  logic [7:0]       r_imm8;

  logic [WIDTH-1:0] w_bShift;
  logic [WIDTH-1:0] w_result;
  logic [1:0]       w_op;
  logic             w_v;

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign c          = r_c;
  assign status_out = r_status;
  assign dbg_data   = r_regs[dbg_addr];

  // Shifter, ALU and overflow detection evaluated from the latched A/B.
  always_comb begin
    w_bShift = r_b;
    w_result = '0;
    w_v      = 1'b0;
    w_op     = (r_kind == KIND_MOVR) ? OP_ADD : r_op;
    if (r_kind != KIND_RI) begin
      case (r_shift)
        2'b01:   w_bShift = {r_b[WIDTH-2:0], 1'b0};
        2'b10:   w_bShift = {1'b0, r_b[WIDTH-1:1]};
        2'b11:   w_bShift = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
        default: w_bShift = r_b;
      endcase
    end
    case (w_op)
      OP_ADD: begin
        w_result = r_a + w_bShift;
        w_v = (r_a[WIDTH-1] == w_bShift[WIDTH-1]) &&
              (w_result[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = r_a - w_bShift;
        w_v = (r_a[WIDTH-1] != w_bShift[WIDTH-1]) &&
              (w_result[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:  w_result = r_a & w_bShift;
      default: w_result = ~w_bShift;
    endcase
  end

  // Command sequencer, operand registers, result/flags and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
      r_done   <= 1'b0;
      r_kind   <= '0;
      r_op     <= '0;
      r_shift  <= '0;
      r_wb     <= 1'b0;
      r_rd     <= '0;
      r_rn     <= '0;
      r_rm     <= '0;
      r_imm5   <= '0;
      r_imm8   <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kind  <= kind;
            r_op    <= ALUop;
            r_shift <= shift;
            r_wb    <= wb;
            r_rd    <= rd;
            r_rn    <= rn;
            r_rm    <= rm;
            r_imm5  <= imm5;
            r_imm8  <= sximm8;
            r_state <= (kind == KIND_MOVI) ? WB : RD_A;
          end
        end
        RD_A: begin
          r_a     <= (r_kind == KIND_MOVR) ? '0 : r_regs[r_rn];
          r_state <= RD_B;
        end
        RD_B: begin
          r_b     <= (r_kind == KIND_RI) ? {{(WIDTH-5){r_imm5[4]}}, r_imm5}
                                         : r_regs[r_rm];
          r_state <= EXEC;
        end
        EXEC: begin
          r_c      <= w_result;
          r_status <= {(w_result == '0), w_v, w_result[WIDTH-1]};
          r_state  <= WB;
        end
        WB: begin
          if (r_kind == KIND_MOVI)
            r_regs[r_rd] <= {{(WIDTH-8){r_imm8[7]}}, r_imm8};
          else if (r_wb)
            r_regs[r_rd] <= r_c;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Testbench for param_datapath: a 16-bit/8-register and a 32-bit/16-register
// instance share command inputs; 'sel' picks which one is started/observed.
module tb_param_datapath;

  localparam logic [1:0] K_RR = 2'b00, K_RI = 2'b01, K_MOVI = 2'b10, K_MOVR = 2'b11;
  localparam logic [1:0] O_ADD = 2'b00, O_SUB = 2'b01, O_AND = 2'b10, O_MVN = 2'b11;
  localparam logic [1:0] S_NONE = 2'b00, S_LSR = 2'b10, S_ASR = 2'b11;

  typedef struct {
    string       tag;
    logic [31:0] c;
    logic [2:0]  st;
    logic [3:0]  rd;
    logic [31:0] rv;
    int          lat;
  } exp_t;

  exp_t sbQueue[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  kind = '0;
  logic [1:0]  aluOp = '0;
  logic [1:0]  shiftSel = '0;
  logic        wbEn = 1'b0;
  logic [3:0]  rd = '0, rn = '0, rm = '0, dbgAddr = '0;
  logic [4:0]  imm5 = '0;
  logic [7:0]  imm8 = '0;

  logic        busy16, done16, busy32, done32;
  logic [15:0] c16, dbg16;
  logic [31:0] c32, dbg32;
  logic [2:0]  st16, st32;
  logic        start16, start32;

  logic [31:0] obsC, obsDbg;
  logic [2:0]  obsSt;
  logic        obsBusy, obsDone;

  int errors = 0;
  int checks = 0;

  assign start16 = start & ~sel;
  assign start32 = start & sel;
  assign obsC    = sel ? c32 : {16'h0, c16};
  assign obsDbg  = sel ? dbg32 : {16'h0, dbg16};
  assign obsSt   = sel ? st32 : st16;
  assign obsBusy = sel ? busy32 : busy16;
  assign obsDone = sel ? done32 : done16;

  always #5 clk = ~clk;

  param_datapath #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .kind(kind), .ALUop(aluOp),
    .shift(shiftSel), .wb(wbEn), .rd(rd[2:0]), .rn(rn[2:0]), .rm(rm[2:0]),
    .imm5(imm5), .sximm8(imm8), .busy(busy16), .done(done16), .c(c16),
    .status_out(st16), .dbg_addr(dbgAddr[2:0]), .dbg_data(dbg16)
  );

  param_datapath #(.WIDTH(32), .NREGS(16)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .kind(kind), .ALUop(aluOp),
    .shift(shiftSel), .wb(wbEn), .rd(rd), .rn(rn), .rm(rm),
    .imm5(imm5), .sximm8(imm8), .busy(busy32), .done(done32), .c(c32),
    .status_out(st32), .dbg_addr(dbgAddr), .dbg_data(dbg32)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [31:0] val);
    dbgAddr = addr;
    #1;
    val = obsDbg;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one command, push its expectation, then pop/compare on done.
  task automatic applyStimulus(input string tag, input logic [1:0] k,
                               input logic [1:0] op, input logic [1:0] sh,
                               input logic w, input logic [3:0] d,
                               input logic [3:0] n, input logic [3:0] m,
                               input logic [4:0] i5, input logic [7:0] i8,
                               input logic [31:0] expC, input logic [2:0] expSt,
                               input logic [31:0] expRv, input bit pulseBusy);
    exp_t e;
    int cnt;
    int extraDone;
    logic [31:0] rv;
    @(negedge clk);
    kind = k; aluOp = op; shiftSel = sh; wbEn = w;
    rd = d; rn = n; rm = m; imm5 = i5; imm8 = i8;
    start = 1'b1;
    sbQueue.push_back('{tag, expC, expSt, d, expRv, (k == K_MOVI) ? 1 : 4});
    @(negedge clk);
    start = 1'b0;
    // Scramble the command inputs to prove they were latched.
    kind = ~k; aluOp = ~op; shiftSel = ~sh; wbEn = ~w;
    rd = ~d; rn = ~n; rm = ~m; imm5 = ~i5; imm8 = ~i8;
    checkOutput({tag, ".busy"}, {31'b0, obsBusy}, 32'd1);
    cnt = 0;
    while (!obsDone && cnt < 16) begin
      @(negedge clk);
      cnt++;
      if (pulseBusy && cnt == 2) start = 1'b1;
      if (cnt == 3) start = 1'b0;
    end
    start = 1'b0;
    e = sbQueue.pop_front();
    checkOutput({e.tag, ".latency"}, cnt, e.lat);
    checkOutput({e.tag, ".c"}, obsC, e.c);
    checkOutput({e.tag, ".status"}, {29'b0, obsSt}, {29'b0, e.st});
    checkOutput({e.tag, ".idle"}, {31'b0, obsBusy}, 32'd0);
    readReg(e.rd, rv);
    checkOutput({e.tag, ".reg"}, rv, e.rv);
    @(negedge clk);
    checkOutput({e.tag, ".donePulse"}, {31'b0, obsDone}, 32'd0);
    if (pulseBusy) begin
      extraDone = 0;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        if (obsDone || obsBusy) extraDone++;
      end
      checkOutput({e.tag, ".ignoredStart"}, extraDone, 0);
      readReg(e.rd, rv);
      checkOutput({e.tag, ".noExtraWrite"}, rv, e.rv);
    end
  endtask

  initial begin
    logic [31:0] rv;
    int doneSeen;

    // ---------------- 16-bit instance ----------------
    sel = 1'b0;
    applyReset();
    @(negedge clk);
    checkOutput("rst.busy", {31'b0, obsBusy}, 32'd0);
    checkOutput("rst.done", {31'b0, obsDone}, 32'd0);
    checkOutput("rst.c", obsC, 32'd0);
    checkOutput("rst.status", {29'b0, obsSt}, 32'd0);
    readReg(4'd0, rv);
    checkOutput("rst.r0", rv, 32'd0);

    applyStimulus("movi_r0", K_MOVI, O_ADD, S_NONE, 1'b1, 4'd0, 4'd0, 4'd0, 5'd0, 8'd50, 32'h0, 3'b000, 32'd50, 1'b0);
    applyStimulus("movi_r1", K_MOVI, O_ADD, S_NONE, 1'b1, 4'd1, 4'd0, 4'd0, 5'd0, 8'd21, 32'h0, 3'b000, 32'd21, 1'b0);
    applyStimulus("add_r2",  K_RR, O_ADD, S_NONE, 1'b1, 4'd2, 4'd0, 4'd1, 5'd0, 8'd0, 32'd71, 3'b000, 32'd71, 1'b0);
    applyStimulus("sub_r3",  K_RR, O_SUB, S_NONE, 1'b1, 4'd3, 4'd1, 4'd0, 5'd0, 8'd0, 32'hFFE3, 3'b001, 32'hFFE3, 1'b0);
    applyStimulus("and_r4",  K_RR, O_AND, S_NONE, 1'b1, 4'd4, 4'd0, 4'd1, 5'd0, 8'd0, 32'h0010, 3'b000, 32'h0010, 1'b0);
    applyStimulus("movi_r5", K_MOVI, O_ADD, S_NONE, 1'b1, 4'd5, 4'd0, 4'd0, 5'd0, 8'h80, 32'h0010, 3'b000, 32'hFF80, 1'b0);
    applyStimulus("asr_r6",  K_MOVR, O_SUB, S_ASR, 1'b1, 4'd6, 4'd3, 4'd5, 5'd0, 8'd0, 32'hFFC0, 3'b001, 32'hFFC0, 1'b0);
    applyStimulus("lsr_r7",  K_MOVR, O_AND, S_LSR, 1'b1, 4'd7, 4'd3, 4'd5, 5'd0, 8'd0, 32'h7FC0, 3'b000, 32'h7FC0, 1'b0);
    applyStimulus("addv_r7", K_RR, O_ADD, S_NONE, 1'b1, 4'd7, 4'd7, 4'd7, 5'd0, 8'd0, 32'hFF80, 3'b011, 32'hFF80, 1'b0);
    applyStimulus("movi_r1b", K_MOVI, O_ADD, S_NONE, 1'b1, 4'd1, 4'd0, 4'd0, 5'd0, 8'd6, 32'hFF80, 3'b011, 32'd6, 1'b0);
    applyStimulus("mvn_r1",  K_RR, O_MVN, S_NONE, 1'b1, 4'd1, 4'd0, 4'd1, 5'd0, 8'd0, 32'hFFF9, 3'b001, 32'hFFF9, 1'b0);
    applyStimulus("addi1",   K_RI, O_ADD, S_ASR, 1'b1, 4'd1, 4'd1, 4'd0, 5'd1, 8'd0, 32'hFFFA, 3'b001, 32'hFFFA, 1'b0);
    applyStimulus("addi10",  K_RI, O_ADD, S_LSR, 1'b1, 4'd1, 4'd1, 4'd0, 5'd10, 8'd0, 32'h0004, 3'b000, 32'h0004, 1'b0);
    applyStimulus("cmp",     K_RR, O_SUB, S_NONE, 1'b0, 4'd2, 4'd0, 4'd0, 5'd0, 8'd0, 32'h0000, 3'b100, 32'd71, 1'b1);

    // Reset while the ADD r3,r0,r1 command sits in EXEC.
    @(negedge clk);
    kind = K_RR; aluOp = O_ADD; shiftSel = S_NONE; wbEn = 1'b1;
    rd = 4'd3; rn = 4'd0; rm = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst.busy", {31'b0, obsBusy}, 32'd0);
    checkOutput("midrst.c", obsC, 32'd0);
    checkOutput("midrst.status", {29'b0, obsSt}, 32'd0);
    doneSeen = 0;
    for (int j = 0; j < 6; j++) begin
      if (obsDone) doneSeen++;
      @(negedge clk);
    end
    checkOutput("midrst.noDone", doneSeen, 0);
    readReg(4'd3, rv);
    checkOutput("midrst.r3", rv, 32'd0);
    readReg(4'd0, rv);
    checkOutput("midrst.r0", rv, 32'd0);

    // Reset coincident with start must not accept the command.
    @(negedge clk);
    kind = K_MOVI; rd = 4'd4; imm8 = 8'd9;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("rststart.busy", {31'b0, obsBusy}, 32'd0);
    @(negedge clk);
    checkOutput("rststart.done", {31'b0, obsDone}, 32'd0);
    readReg(4'd4, rv);
    checkOutput("rststart.r4", rv, 32'd0);

    // ---------------- 32-bit / 16-register instance ----------------
    sel = 1'b1;
    applyReset();
    applyStimulus("w32.movi_r0", K_MOVI, O_ADD, S_NONE, 1'b1, 4'd0, 4'd0, 4'd0, 5'd0, 8'd50, 32'h0, 3'b000, 32'd50, 1'b0);
    applyStimulus("w32.movi_r1", K_MOVI, O_ADD, S_NONE, 1'b1, 4'd1, 4'd0, 4'd0, 5'd0, 8'd21, 32'h0, 3'b000, 32'd21, 1'b0);
    applyStimulus("w32.add_r2",  K_RR, O_ADD, S_NONE, 1'b1, 4'd2, 4'd0, 4'd1, 5'd0, 8'd0, 32'd71, 3'b000, 32'd71, 1'b0);
    applyStimulus("w32.sub_r3",  K_RR, O_SUB, S_NONE, 1'b1, 4'd3, 4'd1, 4'd0, 5'd0, 8'd0, 32'hFFFFFFE3, 3'b001, 32'hFFFFFFE3, 1'b0);
    applyStimulus("w32.movi_r5", K_MOVI, O_ADD, S_NONE, 1'b1, 4'd5, 4'd0, 4'd0, 5'd0, 8'h80, 32'hFFFFFFE3, 3'b001, 32'hFFFFFF80, 1'b0);
    applyStimulus("w32.lsr_r7",  K_MOVR, O_ADD, S_LSR, 1'b1, 4'd7, 4'd0, 4'd5, 5'd0, 8'd0, 32'h7FFFFFC0, 3'b000, 32'h7FFFFFC0, 1'b0);
    applyStimulus("w32.addv_r7", K_RR, O_ADD, S_NONE, 1'b1, 4'd7, 4'd7, 4'd7, 5'd0, 8'd0, 32'hFFFFFF80, 3'b011, 32'hFFFFFF80, 1'b0);
    applyStimulus("w32.add_r12", K_RR, O_ADD, S_NONE, 1'b1, 4'd12, 4'd2, 4'd2, 5'd0, 8'd0, 32'd142, 3'b000, 32'd142, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_datapath.md
# param_datapath

Parametrised, self-sequencing successor to the 16-bit/8-register datapath. A command (kind, ALU op, shift, register numbers, immediates) is captured on a start handshake. An internal FSM then performs the read-A / read-B / execute / write-back sequence that the controller previously drove cycle by cycle. Adds configurable width and register count, a real overflow flag, arithmetic shift right, flag-only compare (write-back suppress), and a debug read port. Sits between the CPU controller FSM and memory interface.

## Interface
- WIDTH, 16, datapath/register width; legal range ≥ 8
- NREGS, 8, register count; power of two, ≥ 2; AW = $clog2(NREGS)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears everything (see Operation)
- start  in  1  command request; sampled only in IDLE
- kind  in  2  00 reg-reg ALU, 01 reg-imm5 ALU, 10 MOV imm8, 11 MOV reg (A forced 0, ADD)
- ALUop  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~B')
- shift  in  2  00 none, 01 LSL1, 10 LSR1 (MSB←0), 11 ASR1 (MSB kept)
- wb  in  1  1 = write result to rd; 0 = flags only (CMP)
- rd, rn, rm  in  AW each  destination, A source, B source
- imm5  in  5  sign-extended to WIDTH, B operand for kind 01
- sximm8  in  8  sign-extended to WIDTH, write value for kind 10
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  registered one-cycle pulse after command retires
- c  out  WIDTH  C register
- status_out  out  3  {Z, V, N}
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  combinational read of R[dbg_addr]

## Operation
- On accept (start=1 in IDLE), latch all command fields. Inputs may change freely afterwards.
- FSM states: IDLE, RD_A, RD_B, EXEC, WB.
  - kinds 00/01/11: IDLE→RD_A→RD_B→EXEC→WB→IDLE.
  - kind 10: IDLE→WB→IDLE.
- RD_A: A ← R[rn]. For kind 11, A ← 0.
- RD_B: B ← imm5 sign-extended for kind 01, else R[rm].
- EXEC:
  - B' = shift(B) for register-sourced B. Immediate B is never shifted.
  - C ← ALU(A, B'), truncated to WIDTH.
  - status_out ← {Z, V, N}: Z = (result==0), N = result[WIDTH-1].
  - V for ADD: A and B' have the same sign and the result sign differs.
  - V for SUB (A−B'): A and B' have different signs and the result sign differs from A.
  - V = 0 for AND and MVN.
- WB:
  - kinds 00/01/11: R[rd] ← C if latched wb=1, else no write.
  - kind 10: R[rd] ← sign-extended sximm8, unconditionally. C and status_out are unchanged.
  - done ← 1 for one cycle. state ← IDLE.
- start while busy: ignored, no queueing, no error.
- Reads in RD_A/RD_B see the register file as of that edge. rd==rn or rd==rm needs no special handling because writes happen only in WB.
- reset (any state, including mid-command):
  - state←IDLE; A, B, C, status_out←0; done←0; all R[i]←0.
  - Any in-flight write is dropped.
  - A reset coincident with start does not accept the command.

## Timing
- Edge n samples start in IDLE.
- ALU kinds: A latched at n+1, B at n+2, C/status at n+3, register write and done←1 at n+4.
  - done is high for cycle n+4..n+5. busy is high from n+1 through n+4.
  - Earliest next accept is edge n+5, giving 5-cycle throughput.
- MOV imm: write and done←1 at edge n+1. Earliest next accept is n+2.
- dbg_data reflects a WB write in the cycle after the write edge.
- c/status_out hold their value between EXEC edges.

## Test plan
- Reset, then MOV imm r0=50 and r1=21 → dbg reads 50, 21; c=0 and status=000 throughout; done pulses 1 cycle after each accept.
- ADD r2,r0,r1 → c=71, status=000, r2=71. SUB r3,r1,r0 → c=0xFFE3 (−29), status=001. AND r4,r0,r1 → 0x0010. Check done exactly 4 edges after accept.
- Shifts: MOV imm r5=−128 (0xFF80).
  - MOV reg r6←r5 ASR1 → 0xFFC0, status 001.
  - MOV reg r7←r5 LSR1 → 0x7FC0, status 000.
  - ADD r7,r7,r7 → 0xFF80, status 011 (V=1, N=1).
- Immediate and MVN: MOV imm r1=6; MVN r1←r1 → 0xFFF9; ADD-imm r1,r1,#1 → 0xFFFA; ADD-imm r1,r1,#10 → 0x0004, status 000.
- CMP: SUB r0,r0 with wb=0, rd=r2 → status 100, r2 still 71. A start pulsed during the busy cycles is ignored: exactly one done, no extra write.
- Reset mid-op: assert reset in EXEC of ADD r3,r0,r1 → r3=0, c=0, status=000, done never pulses, busy=0 next cycle. WIDTH=32, NREGS=16 rerun of the ADD/overflow cases passes.
